// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a one-entry
// hold buffer that parks a fetched word while the hazard unit stalls decode.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h00000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] instr_out,
    output logic [31:0] pc4_out,
    output logic        valid_out,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] holdInstr_q, holdInstr_d;
    logic [31:0] holdPc4_q, holdPc4_d;
    logic        halted_q, halted_d;

    logic [31:0] pcPlus4;
    logic [31:0] redirectAligned;

    assign pcPlus4         = pc_q + 32'd4;
    assign redirectAligned = redirect_pc & 32'hFFFF_FFFC;

    assign iREN      = (state_q == FETCH) && !RST;
    assign iaddr     = pc_q;
    assign instr_out = instr_q;
    assign pc4_out   = pc4_q;
    assign valid_out = valid_q;
    assign halted    = halted_q;

    // Priority chain: redirect beats halt, which beats the normal stall/ihit handling.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        holdInstr_d = holdInstr_q;
        holdPc4_d   = holdPc4_q;
        halted_d    = halted_q;

        if (state_q == HALT) begin
            state_d = HALT;
        end else if (redirect) begin
            pc_d        = redirectAligned;
            instr_d     = 32'h0;
            pc4_d       = 32'h0;
            valid_d     = 1'b0;
            holdInstr_d = 32'h0;
            holdPc4_d   = 32'h0;
            state_d     = FETCH;
        end else if (halt) begin
            instr_d  = 32'h0;
            pc4_d    = 32'h0;
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = HALT;
        end else if (state_q == FETCH) begin
            if (ihit && !stall) begin
                instr_d = iload;
                pc4_d   = pcPlus4;
                valid_d = 1'b1;
                pc_d    = pcPlus4;
            end else if (ihit && stall) begin
                // Word already arrived; park it so it is neither lost nor refetched.
                holdInstr_d = iload;
                holdPc4_d   = pcPlus4;
                pc_d        = pcPlus4;
                state_d     = HOLD;
            end else if (!stall) begin
                instr_d = 32'h0;
                pc4_d   = 32'h0;
                valid_d = 1'b0;
            end
        end else begin
            if (!stall) begin
                instr_d = holdInstr_q;
                pc4_d   = holdPc4_q;
                valid_d = 1'b1;
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= FETCH;
            pc_q        <= PC_INIT;
            instr_q     <= 32'h0;
            pc4_q       <= 32'h0;
            valid_q     <= 1'b0;
            holdInstr_q <= 32'h0;
            holdPc4_q   <= 32'h0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            holdInstr_q <= holdInstr_d;
            holdPc4_q   <= holdPc4_d;
            halted_q    <= halted_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: straight-line fetch, memory latency, stall/hold,
// redirect priority, halt and PC wrap, all against hand-computed values.
module tb_fetch_stage;

    logic        CLK;
    logic        RST;
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] instr_out;
    logic [31:0] pc4_out;
    logic        valid_out;
    logic        halted;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.PC_INIT(32'h00000000)) dut (
        .CLK(CLK),
        .RST(RST),
        .ihit(ihit),
        .iload(iload),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .iREN(iREN),
        .iaddr(iaddr),
        .instr_out(instr_out),
        .pc4_out(pc4_out),
        .valid_out(valid_out),
        .halted(halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory returns a word tagged with the address it was fetched from.
    assign iload = {16'hC0DE, iaddr[15:0]};

    task automatic applyStimulus();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkIfId(input string tag, input logic [31:0] expInstr,
                             input logic [31:0] expPc4, input logic expValid);
        checkOutput({tag, ".instr"}, instr_out, expInstr);
        checkOutput({tag, ".pc4"}, pc4_out, expPc4);
        checkOutput({tag, ".valid"}, {31'h0, valid_out}, {31'h0, expValid});
    endtask

    task automatic checkFetch(input string tag, input logic [31:0] expAddr,
                              input logic expRen, input logic expHalted);
        checkOutput({tag, ".iaddr"}, iaddr, expAddr);
        checkOutput({tag, ".iREN"}, {31'h0, iREN}, {31'h0, expRen});
        checkOutput({tag, ".halted"}, {31'h0, halted}, {31'h0, expHalted});
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; halt = 1'b0;
        applyStimulus();
        applyStimulus();
        checkIfId("reset", 32'h0, 32'h0, 1'b0);
        checkFetch("reset", 32'h0, 1'b0, 1'b0);

        // Straight-line fetch
        RST = 1'b0; ihit = 1'b1;
        #1;
        checkFetch("firstReq", 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkIfId("line0", 32'hC0DE0000, 32'h4, 1'b1);
        applyStimulus();
        checkIfId("line4", 32'hC0DE0004, 32'h8, 1'b1);
        applyStimulus();
        checkIfId("line8", 32'hC0DE0008, 32'hC, 1'b1);
        checkFetch("line8", 32'hC, 1'b1, 1'b0);
        applyStimulus();
        checkIfId("lineC", 32'hC0DE000C, 32'h10, 1'b1);

        // Memory latency at 0x10
        ihit = 1'b0;
        applyStimulus();
        checkIfId("miss1", 32'h0, 32'h0, 1'b0);
        checkFetch("miss1", 32'h10, 1'b1, 1'b0);
        applyStimulus();
        checkIfId("miss2", 32'h0, 32'h0, 1'b0);
        ihit = 1'b1;
        applyStimulus();
        checkIfId("hit10", 32'hC0DE0010, 32'h14, 1'b1);
        checkFetch("hit10", 32'h14, 1'b1, 1'b0);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkIfId("line1C", 32'hC0DE001C, 32'h20, 1'b1);
        checkFetch("line1C", 32'h20, 1'b1, 1'b0);

        // Stall with hit at 0x20 for three cycles
        stall = 1'b1;
        applyStimulus();
        checkIfId("hold1", 32'hC0DE001C, 32'h20, 1'b1);
        checkFetch("hold1", 32'h24, 1'b0, 1'b0);
        applyStimulus();
        applyStimulus();
        checkIfId("hold3", 32'hC0DE001C, 32'h20, 1'b1);
        checkFetch("hold3", 32'h24, 1'b0, 1'b0);
        stall = 1'b0;
        applyStimulus();
        checkIfId("release", 32'hC0DE0020, 32'h24, 1'b1);
        checkFetch("release", 32'h24, 1'b1, 1'b0);
        applyStimulus();
        checkIfId("after24", 32'hC0DE0024, 32'h28, 1'b1);

        // Redirect beats stall and halt while in HOLD
        stall = 1'b1;
        applyStimulus();
        checkFetch("hold28", 32'h2C, 1'b0, 1'b0);
        redirect = 1'b1; redirect_pc = 32'h103; halt = 1'b1;
        applyStimulus();
        checkIfId("redir", 32'h0, 32'h0, 1'b0);
        checkFetch("redir", 32'h100, 1'b1, 1'b0);
        redirect = 1'b0; halt = 1'b0; stall = 1'b0;
        applyStimulus();
        checkIfId("tgt100", 32'hC0DE0100, 32'h104, 1'b1);

        // Stall with miss in FETCH keeps everything
        ihit = 1'b0; stall = 1'b1;
        applyStimulus();
        checkIfId("missStall", 32'hC0DE0100, 32'h104, 1'b1);
        checkFetch("missStall", 32'h104, 1'b1, 1'b0);
        ihit = 1'b1; stall = 1'b0;

        // Halt at 0x40, then redirect must be ignored
        redirect = 1'b1; redirect_pc = 32'h40;
        applyStimulus();
        redirect = 1'b0; halt = 1'b1;
        applyStimulus();
        checkIfId("halt", 32'h0, 32'h0, 1'b0);
        checkFetch("halt", 32'h40, 1'b0, 1'b1);
        halt = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
        applyStimulus();
        checkIfId("haltIgn", 32'h0, 32'h0, 1'b0);
        checkFetch("haltIgn", 32'h40, 1'b0, 1'b1);
        redirect = 1'b0;
        RST = 1'b1;
        applyStimulus();
        checkFetch("haltRst", 32'h0, 1'b0, 1'b0);
        RST = 1'b0;
        #1;
        checkFetch("postRst", 32'h0, 1'b1, 1'b0);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
        applyStimulus();
        checkFetch("wrapTgt", 32'hFFFFFFFC, 1'b1, 1'b0);
        redirect = 1'b0;
        applyStimulus();
        checkIfId("wrap", 32'hC0DEFFFC, 32'h0, 1'b1);
        checkFetch("wrap", 32'h0, 1'b1, 1'b0);
        applyStimulus();
        checkIfId("wrapNext", 32'hC0DE0000, 32'h4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h00000000, PC value loaded at reset.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ihit  input  1  instruction memory returns iload for iaddr this cycle.
REQ-005 SHALL have port iload  input  32  instruction word from memory, valid when ihit=1.
REQ-006 SHALL have port stall  input  1  hazard unit holds IF/ID and PC.
REQ-007 SHALL have port redirect  input  1  branch/jump resolved taken; squash and refetch.
REQ-008 SHALL have port redirect_pc  input  32  target address for redirect.
REQ-009 SHALL have port halt  input  1  decode has detected HALT opcode.
REQ-010 SHALL have port iREN  output  1  instruction read request.
REQ-011 SHALL have port iaddr  output  32  instruction fetch address, equal to PC.
REQ-012 SHALL have port instr_out  output  32  IF/ID instruction, drives control unit instr input.
REQ-013 SHALL have port pc4_out  output  32  IF/ID PC+4 of instr_out (JAL link, branch base).
REQ-014 SHALL have port valid_out  output  1  IF/ID holds a real instruction, not a bubble.
REQ-015 SHALL have port halted  output  1  fetch permanently stopped until reset.

Function
REQ-016 SHALL implement three states: FETCH, HOLD, HALT; iREN=1 only in FETCH; iaddr=PC in all states.
REQ-017 SHALL define a bubble as instr_out=32'h00000000 (SLL r0 NOP), pc4_out=0, valid_out=0.
REQ-018 SHALL apply per-cycle priority: RST > redirect > halt > (stall/ihit handling).
REQ-019 redirect (any state except HALT): PC<=redirect_pc with bits[1:0] forced to 00; IF/ID<=bubble; HOLD buffer discarded; next state FETCH; overrides stall and same-cycle ihit.
REQ-020 halt without redirect (FETCH or HOLD): PC frozen; IF/ID<=bubble; next state HALT; halted=1 from the following cycle.
REQ-021 HALT SHALL ignore redirect, stall and ihit; PC, IF/ID, halted frozen until RST.
REQ-022 FETCH, ihit=1, stall=0: IF/ID<={iload, PC+4, 1}; PC<=PC+4; remain FETCH (1-cycle latency from ihit to instr_out).
REQ-023 FETCH, ihit=1, stall=1: hold buffer<={iload, PC+4}; PC<=PC+4; IF/ID unchanged; next state HOLD.
REQ-024 FETCH, ihit=0, stall=0: IF/ID<=bubble; PC unchanged; remain FETCH with iREN held.
REQ-025 FETCH, ihit=0, stall=1: IF/ID and PC unchanged.
REQ-026 HOLD, stall=1: all state unchanged, iREN=0.
REQ-027 HOLD, stall=0: IF/ID<={hold buffer, 1}; next state FETCH; PC already advanced, not incremented again.
REQ-028 PC+4 SHALL be computed modulo 2^32: 32'hFFFFFFFC advances to 32'h00000000.
REQ-029 No instruction SHALL be lost or duplicated across any stall/ihit/redirect interleaving.

Reset
REQ-030 RST=1 at a rising edge SHALL set PC=PC_INIT, state FETCH, IF/ID=bubble, hold buffer=0, halted=0, regardless of state, including mid-HOLD or HALT.
REQ-031 While RST=1, iREN SHALL be 0; first request issued in the cycle after RST deasserts with iaddr=PC_INIT.

Verification
REQ-032 Straight-line: reset, ihit=1 every cycle, iload=PC-tagged words -> instr_out sequence words for 0x0,0x4,0x8, pc4_out 0x4,0x8,0xC, valid_out=1.
REQ-033 Memory latency: ihit low 2 cycles at PC=0x10 -> two bubbles (valid_out=0), then instr at 0x10 with pc4_out=0x14, PC never skips.
REQ-034 Stall with hit: stall=1 for 3 cycles while ihit=1 at PC=0x20 -> state HOLD, iREN=0, instr_out unchanged; on release instr from 0x20 appears once, next fetch 0x24.
REQ-035 Redirect vs stall/halt: redirect=1, redirect_pc=0x103, stall=1, halt=1 same cycle in HOLD -> PC=0x100, bubble, state FETCH, halted=0, held word discarded.
REQ-036 Halt: halt=1 at PC=0x40 -> bubble, iREN=0, halted=1 next cycle; later redirect ignored; RST restores PC=PC_INIT, halted=0.
REQ-037 Wrap: redirect_pc=0xFFFFFFFC, ihit=1 -> pc4_out=0x00000000, next iaddr=0x00000000.
